// File: rtl/regfile_write_queue.sv
// regfile_write_queue
//
// In-order write-back queue that sits in front of the register file write port.
// ALU and load results are accepted, buffered in a small circular queue, and
// presented one at a time to the register file. The head entry stays on the
// write port until the register file acknowledges it. The queue also reports,
// for both read-port addresses, whether a write is still queued, along with the
// youngest queued value for that register.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   alu_valid/ready       ALU result handshake; alu_register, alu_data payload
//   load_valid/ready      load result handshake; load_register, load_data payload
//   write_register/data   head entry toward the register file (zero when empty)
//   write_data_valid      queue holds at least one entry
//   write_valid           register file acknowledge; retires the head entry
//   read_register_1/2     read-port addresses being looked up
//   pending_1/2           a queued write to that address exists
//   forward_data_1/2      youngest queued value for that address (zero if none)
//   empty                 queue holds no entries
//
// Handshake semantics: a transfer happens at a rising edge where valid and
// ready are both high. Ready depends only on registered state (plus alu_valid
// for the load port) and never waits for valid. A source that raises valid
// keeps it, and its payload, stable until the transfer happens. On the drain
// side, write_data_valid acts as valid and write_valid acts as ready.

module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int ADDR  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [ADDR-1:0]  alu_register,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [ADDR-1:0]  load_register,
    input  logic [WIDTH-1:0] load_data,
    output logic [ADDR-1:0]  write_register,
    output logic [WIDTH-1:0] write_data,
    output logic             write_data_valid,
    input  logic             write_valid,
    input  logic [ADDR-1:0]  read_register_1,
    input  logic [ADDR-1:0]  read_register_2,
    output logic             pending_1,
    output logic             pending_2,
    output logic [WIDTH-1:0] forward_data_1,
    output logic [WIDTH-1:0] forward_data_2,
    output logic             empty
);

    localparam int PTR = $clog2(DEPTH);
    localparam int CNT = $clog2(DEPTH + 1);

    logic [ADDR-1:0]  reg_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [PTR-1:0]   head;
    logic [PTR-1:0]   tail;
    logic [CNT-1:0]   count;

    logic             alu_enq;
    logic             alu_take;
    logic             load_take;
    logic             retire;
    logic [PTR-1:0]   load_slot;

    // Writes to x0 complete the handshake but take no queue slot.
    assign alu_enq   = alu_valid && (alu_register != '0);
    assign alu_ready = (count < CNT'(DEPTH));
    // The load port reserves room for a same-cycle ALU entry, which is older.
    assign load_ready = ((count + CNT'(alu_enq)) < CNT'(DEPTH));

    assign alu_take  = alu_enq && alu_ready;
    assign load_take = load_valid && load_ready && (load_register != '0);
    assign retire    = write_data_valid && write_valid;
    assign load_slot = tail + PTR'(alu_take);

    assign write_data_valid = (count != '0);
    assign empty            = (count == '0);
    assign write_register   = write_data_valid ? reg_mem[head]  : '0;
    assign write_data       = write_data_valid ? data_mem[head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alu_take) begin
                reg_mem[tail]  <= alu_register;
                data_mem[tail] <= alu_data;
            end
            if (load_take) begin
                reg_mem[load_slot]  <= load_register;
                data_mem[load_slot] <= load_data;
            end
            if (retire) begin
                head <= head + PTR'(1);
            end
            tail  <= tail + PTR'(alu_take) + PTR'(load_take);
            count <= count + CNT'(alu_take) + CNT'(load_take) - CNT'(retire);
        end
    end

    // Walk the valid entries oldest to youngest, starting from head, so the
    // last match seen is the youngest one regardless of physical position.
    always_comb begin
        logic [PTR-1:0] idx;
        idx            = '0;
        pending_1      = 1'b0;
        pending_2      = 1'b0;
        forward_data_1 = '0;
        forward_data_2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR'(i);
            if (CNT'(i) < count) begin
                if ((read_register_1 != '0) && (reg_mem[idx] == read_register_1)) begin
                    pending_1      = 1'b1;
                    forward_data_1 = data_mem[idx];
                end
                if ((read_register_2 != '0) && (reg_mem[idx] == read_register_2)) begin
                    pending_2      = 1'b1;
                    forward_data_2 = data_mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue
//
// Bench for regfile_write_queue. It keeps a reference queue of {register, data}
// entries, updated each clock from the accept/retire rules. Each scenario task
// drives inputs on the falling edge and compares DUT outputs against the
// reference just after that.

module tb_regfile_write_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int ADDR  = 5;

    logic             clk;
    logic             rst;
    logic             alu_valid;
    logic             alu_ready;
    logic [ADDR-1:0]  alu_register;
    logic [WIDTH-1:0] alu_data;
    logic             load_valid;
    logic             load_ready;
    logic [ADDR-1:0]  load_register;
    logic [WIDTH-1:0] load_data;
    logic [ADDR-1:0]  write_register;
    logic [WIDTH-1:0] write_data;
    logic             write_data_valid;
    logic             write_valid;
    logic [ADDR-1:0]  read_register_1;
    logic [ADDR-1:0]  read_register_2;
    logic             pending_1;
    logic             pending_2;
    logic [WIDTH-1:0] forward_data_1;
    logic [WIDTH-1:0] forward_data_2;
    logic             empty;

    int checks;
    int failures;

    // Reference queue, oldest entry at index 0.
    logic [ADDR-1:0]  exp_reg_q[$];
    logic [WIDTH-1:0] exp_q[$];

    regfile_write_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_register(alu_register), .alu_data(alu_data),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_register(load_register), .load_data(load_data),
        .write_register(write_register), .write_data(write_data),
        .write_data_valid(write_data_valid), .write_valid(write_valid),
        .read_register_1(read_register_1), .read_register_2(read_register_2),
        .pending_1(pending_1), .pending_2(pending_2),
        .forward_data_1(forward_data_1), .forward_data_2(forward_data_2),
        .empty(empty)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive_idle();
        alu_valid = 1'b0; alu_register = '0; alu_data = '0;
        load_valid = 1'b0; load_register = '0; load_data = '0;
        write_valid = 1'b0;
    endtask

    task automatic drive_alu(input logic [ADDR-1:0] r, input logic [WIDTH-1:0] d);
        alu_valid = 1'b1; alu_register = r; alu_data = d;
    endtask

    task automatic drive_load(input logic [ADDR-1:0] r, input logic [WIDTH-1:0] d);
        load_valid = 1'b1; load_register = r; load_data = d;
    endtask

    // Advance one clock and apply the same edge to the reference queue.
    task automatic tick();
        int  n;
        bit  acc_alu, acc_load, ret;
        n        = exp_q.size();
        acc_alu  = alu_valid && (n < DEPTH);
        acc_load = load_valid && ((n + ((alu_valid && alu_register != 0) ? 1 : 0)) < DEPTH);
        ret      = write_valid && (n > 0);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_reg_q.delete();
        end else begin
            if (ret) begin
                void'(exp_q.pop_front());
                void'(exp_reg_q.pop_front());
            end
            if (acc_alu && alu_register != 0) begin
                exp_reg_q.push_back(alu_register);
                exp_q.push_back(alu_data);
            end
            if (acc_load && load_register != 0) begin
                exp_reg_q.push_back(load_register);
                exp_q.push_back(load_data);
            end
        end
        @(negedge clk);
    endtask

    // Reference lookups: youngest match wins.
    function automatic logic m_pending(input logic [ADDR-1:0] rr);
        if (rr == 0) return 1'b0;
        foreach (exp_reg_q[i]) if (exp_reg_q[i] == rr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [WIDTH-1:0] m_forward(input logic [ADDR-1:0] rr);
        logic [WIDTH-1:0] v;
        v = '0;
        if (rr != 0)
            foreach (exp_reg_q[i]) if (exp_reg_q[i] == rr) v = exp_q[i];
        return v;
    endfunction

    function automatic logic [ADDR-1:0] m_head_reg();
        return (exp_q.size() > 0) ? exp_reg_q[0] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_head_data();
        return (exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    // Scenarios
    task automatic test_reset();
        drive_idle();
        read_register_1 = 5'd1; read_register_2 = 5'd2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (write_data_valid !== 1'b0) begin failures++; $display("FAIL reset_wdv got=%0b exp=0", write_data_valid); end
            checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
            checks++; if ({pending_1, pending_2} !== 2'b00) begin failures++; $display("FAIL reset_pending got=%b exp=00", {pending_1, pending_2}); end
            checks++; if ({alu_ready, load_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", {alu_ready, load_ready}); end
            checks++; if (write_data !== '0 || write_register !== '0) begin failures++; $display("FAIL reset_wport got=%h/%h exp=0/0", write_register, write_data); end
            tick();
        end
    endtask

    task automatic test_single_ack();
        drive_idle();
        drive_alu(5'd1, 32'hdead_beef);
        tick();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            write_valid = (c == 2);
            #1;
            checks++; if (write_register !== 5'd1 || write_data !== 32'hdead_beef || write_data_valid !== 1'b1) begin
                failures++; $display("FAIL single_hold c=%0d got=%h/%h/%b exp=01/deadbeef/1", c, write_register, write_data, write_data_valid);
            end
            tick();
        end
        drive_idle();
        #1;
        checks++; if (empty !== 1'b1 || write_data_valid !== 1'b0) begin failures++; $display("FAIL single_retired got=%b/%b exp=1/0", empty, write_data_valid); end
    endtask

    task automatic test_dual_same_reg();
        drive_idle();
        drive_alu(5'd2, 32'h1111_1111);
        drive_load(5'd2, 32'h2222_2222);
        read_register_1 = 5'd2;
        #1;
        checks++; if ({alu_ready, load_ready} !== 2'b11) begin failures++; $display("FAIL dual_ready got=%b exp=11", {alu_ready, load_ready}); end
        tick();
        drive_idle();
        #1;
        checks++; if (pending_1 !== 1'b1 || forward_data_1 !== 32'h2222_2222) begin
            failures++; $display("FAIL dual_forward got=%b/%h exp=1/22222222", pending_1, forward_data_1);
        end
        write_valid = 1'b1;
        checks++; if (write_data !== 32'h1111_1111) begin failures++; $display("FAIL dual_first got=%h exp=11111111", write_data); end
        tick();
        #1;
        checks++; if (write_register !== 5'd2 || write_data !== 32'h2222_2222) begin failures++; $display("FAIL dual_second got=%h/%h exp=02/22222222", write_register, write_data); end
        tick();
        drive_idle();
        #1;
        checks++; if (empty !== 1'b1 || pending_1 !== 1'b0) begin failures++; $display("FAIL dual_drained got=%b/%b exp=1/0", empty, pending_1); end
    endtask

    task automatic test_reg_zero();
        drive_idle();
        drive_alu(5'd0, 32'hffff_ffff);
        drive_load(5'd0, 32'hffff_ffff);
        #1;
        checks++; if ({alu_ready, load_ready} !== 2'b11) begin failures++; $display("FAIL zero_ready got=%b exp=11", {alu_ready, load_ready}); end
        tick();
        drive_idle();
        #1;
        checks++; if (empty !== 1'b1 || write_data_valid !== 1'b0) begin failures++; $display("FAIL zero_enqueued got=%b/%b exp=1/0", empty, write_data_valid); end
    endtask

    task automatic test_full_and_wrap();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            drive_alu(ADDR'(8 + i), $urandom);
            tick();
        end
        drive_alu(5'd5, 32'h5555_0005);
        drive_load(5'd6, 32'h6666_0006);
        #1;
        checks++; if ({alu_ready, load_ready} !== 2'b10) begin failures++; $display("FAIL count3_ready got=%b exp=10", {alu_ready, load_ready}); end
        tick();
        drive_idle();
        drive_load(5'd6, 32'h6666_0006);
        #1;
        checks++; if ({alu_ready, load_ready} !== 2'b00) begin failures++; $display("FAIL full_ready got=%b exp=00", {alu_ready, load_ready}); end
        drive_idle();
        write_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (write_register !== m_head_reg() || write_data !== m_head_data()) begin
                failures++; $display("FAIL full_drain i=%0d got=%h/%h exp=%h/%h", i, write_register, write_data, m_head_reg(), m_head_data());
            end
            tick();
        end
        // Refill across the physical end of the buffer with repeated targets.
        drive_idle();
        drive_alu(5'd7, 32'h0000_00a1);
        drive_load(5'd7, 32'h0000_00a2);
        tick();
        drive_idle();
        drive_alu(5'd7, 32'h0000_00a3);
        tick();
        drive_idle();
        read_register_1 = 5'd7; read_register_2 = 5'd9;
        #1;
        checks++; if (pending_1 !== 1'b1 || forward_data_1 !== 32'h0000_00a3) begin failures++; $display("FAIL wrap_forward got=%b/%h exp=1/000000a3", pending_1, forward_data_1); end
        checks++; if (pending_2 !== 1'b0 || forward_data_2 !== '0) begin failures++; $display("FAIL wrap_nomatch got=%b/%h exp=0/0", pending_2, forward_data_2); end
        write_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (write_data !== 32'h0000_00a1 + WIDTH'(i)) begin failures++; $display("FAIL wrap_order i=%0d got=%h exp=%h", i, write_data, 32'h0000_00a1 + WIDTH'(i)); end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_drain();
        drive_idle();
        drive_alu(5'd3, 32'h3333_3333);
        drive_load(5'd4, 32'h4444_4444);
        tick();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_register_1 = 5'd3; read_register_2 = 5'd4;
        write_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (write_data_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL rstmid_state c=%0d got=%b/%b exp=0/1", c, write_data_valid, empty); end
            checks++; if ({pending_1, pending_2} !== 2'b00) begin failures++; $display("FAIL rstmid_pending c=%0d got=%b exp=00", c, {pending_1, pending_2}); end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            alu_valid     = 1'($urandom_range(0, 1));
            alu_register  = ADDR'($urandom_range(0, 7));
            alu_data      = $urandom;
            load_valid    = 1'($urandom_range(0, 1));
            load_register = ADDR'($urandom_range(0, 7));
            load_data     = $urandom;
            write_valid   = ($urandom_range(0, 99) < (((c / 50) % 2 == 0) ? 30 : 85));
            read_register_1 = ADDR'($urandom_range(0, 7));
            read_register_2 = ADDR'($urandom_range(0, 7));
            #1;
            checks++; if (write_data_valid !== (exp_q.size() != 0) || empty !== (exp_q.size() == 0)) begin
                failures++; $display("FAIL rand_valid c=%0d got=%b/%b exp_size=%0d", c, write_data_valid, empty, exp_q.size());
            end
            checks++; if (write_register !== m_head_reg() || write_data !== m_head_data()) begin
                failures++; $display("FAIL rand_head c=%0d got=%h/%h exp=%h/%h", c, write_register, write_data, m_head_reg(), m_head_data());
            end
            checks++; if (alu_ready !== (exp_q.size() < DEPTH)) begin
                failures++; $display("FAIL rand_alu_ready c=%0d got=%b size=%0d", c, alu_ready, exp_q.size());
            end
            checks++; if (load_ready !== ((exp_q.size() + ((alu_valid && alu_register != 0) ? 1 : 0)) < DEPTH)) begin
                failures++; $display("FAIL rand_load_ready c=%0d got=%b size=%0d", c, load_ready, exp_q.size());
            end
            checks++; if (pending_1 !== m_pending(read_register_1) || forward_data_1 !== m_forward(read_register_1)) begin
                failures++; $display("FAIL rand_fwd1 c=%0d got=%b/%h exp=%b/%h", c, pending_1, forward_data_1, m_pending(read_register_1), m_forward(read_register_1));
            end
            checks++; if (pending_2 !== m_pending(read_register_2) || forward_data_2 !== m_forward(read_register_2)) begin
                failures++; $display("FAIL rand_fwd2 c=%0d got=%b/%h exp=%b/%h", c, pending_2, forward_data_2, m_pending(read_register_2), m_forward(read_register_2));
            end
            tick();
        end
        drive_idle();
    endtask

    // Final report
    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive_idle();
        read_register_1 = '0;
        read_register_2 = '0;
        @(negedge clk);
        test_reset();
        test_single_ack();
        test_dual_same_reg();
        test_reg_zero();
        test_full_and_wrap();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
